hazard_ctrl: RTL

Pipeline hazard controller: the control source that drives the program counter's write enable (`pc_write` feeds the PC's `PCWrite` input) and the pipeline-register enables and flushes. Each cycle it arbitrates between three events: a data-memory wait, a taken branch or jump resolved in EX, and a load-use dependency between ID and EX. It holds a small FSM that tracks multi-cycle memory waits with a timeout. It also keeps saturating performance counters for stall and flush cycles.

---
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: arbitrates memory waits, taken branches and
// load-use dependencies into PC / pipeline-register enables and flushes.
// Tracks memory waits in a small FSM with a sticky timeout flag and keeps
// saturating stall / flush performance counters.
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             pc_sel_target,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             pipe_hold,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

   state_t           state_q, state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic             mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic mem_stall;
   logic load_use;
   logic branch_go;

   // x0 is never written, so a load targeting it can never create a hazard.
   assign mem_stall = dmem_req & ~dmem_ready;
   assign load_use  = ex_mem_read & (ex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));
   // A branch is only honoured when no memory wait freezes the pipeline.
   assign branch_go = ex_branch_taken & ~mem_stall;

   // Strict-priority arbitration of the combinational control outputs.
   always_comb begin
      pc_write      = 1'b1;
      pc_sel_target = 1'b0;
      ifid_write    = 1'b1;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;
      pipe_hold     = 1'b0;
      if (reset) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (mem_stall) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         pipe_hold  = 1'b1;
      end else if (ex_branch_taken) begin
         pc_sel_target = 1'b1;
         ifid_flush    = 1'b1;
         idex_flush    = 1'b1;
      end else if (load_use) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         idex_flush = 1'b1;
      end
   end

   // Memory-wait FSM next state, wait length tracking and sticky timeout.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q | ((wait_cnt_q == TIMEOUT_CNT) & mem_stall);
      case (state_q)
         RUN: begin
            if (mem_stall) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (mem_stall) begin
               if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
            end else begin
               state_d    = RUN;
               wait_cnt_d = 8'd0;
            end
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = 8'd0;
         end
      endcase
   end

   // Saturating performance counters; they stick at all-ones.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (~pc_write && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (branch_go && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   // State, timeout flag and counters register; reset clears everything at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= RUN;
         wait_cnt_q    <= 8'd0;
         mem_timeout_q <= 1'b0;
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
         stall_cnt_q   <= stall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
      end
   end

   assign mem_timeout = mem_timeout_q;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;

endmodule
